// File: rtl/ob_cmd_mux_pkg.sv
// ob_cmd_mux_pkg: shared types and default sizes for the multi-channel order-book command front end.
package ob_cmd_mux_pkg;
    localparam int CH_MAX  = 16;
    localparam int OB_CH_N = 4;
    localparam int OB_IQ_N = 4;
    localparam int OB_EQ_N = 4;

    typedef logic [$clog2(CH_MAX)-1:0] ch_t;

    typedef enum logic [1:0] {CMD_ADD, CMD_CANCEL, CMD_MODIFY, CMD_QUERY} cmd_op_e;
    typedef enum logic [1:0] {RSP_ACK, RSP_FILL, RSP_REJ, RSP_INFO} rsp_kind_e;

    typedef struct packed {
        cmd_op_e     op;
        logic [29:0] arg;
    } cmd_t;

    typedef struct packed {
        rsp_kind_e   kind;
        logic [29:0] arg;
    } rsp_t;
endpackage

// File: rtl/ob_cmd_mux_rr_arb.sv
// ob_cmd_mux_rr_arb: round-robin arbiter; grants the first requester at or after the pointer,
// and moves the pointer just past the grant when the grant is accepted.
module ob_cmd_mux_rr_arb #(
    parameter int N = 4,
    localparam int AW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_accept,
    output logic [N-1:0]  o_gnt,
    output logic [AW-1:0] o_idx
);
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_lo;
    logic [AW-1:0] w_hi;
    logic          w_hit;

    // Descending scan leaves the lowest requester overall and the lowest one at/after the pointer.
    always_comb begin
        w_lo  = '0;
        w_hi  = '0;
        w_hit = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) w_lo = AW'(j);
            if (i_req[j] && j >= int'(r_ptr)) begin
                w_hi  = AW'(j);
                w_hit = 1'b1;
            end
        end
    end

    assign o_idx = w_hit ? w_hi : w_lo;
    assign o_gnt = |i_req ? N'(1) << o_idx : '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_ptr <= '0;
        else if (i_accept)
            r_ptr <= (o_idx == AW'(N - 1)) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/ob_cmd_mux.sv
// ob_cmd_mux: CH_N-channel command ingress queues, round-robin feed to ob_cntrl, owner-routed egress queues.
// Define OB_CMD_MUX_STATS_EN to add per-channel pop and egress-push counters.
module ob_cmd_mux
    import ob_cmd_mux_pkg::*;
#(
    parameter int CH_N = OB_CH_N,
    parameter int IQ_N = OB_IQ_N,
    parameter int EQ_N = OB_EQ_N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_N-1:0] cmd_vld_r,
    input  cmd_t            cmd_r [CH_N],
    output logic [CH_N-1:0] cmd_full_r,
    input  logic [CH_N-1:0] rsp_accept,
    output logic [CH_N-1:0] rsp_vld,
    output rsp_t            rsp [CH_N],
    output logic            cntrl_cmd_vld,
    output cmd_t            cntrl_cmd,
    input  logic            cntrl_cmd_pop,
    input  logic            cntrl_rsp_vld,
    input  rsp_t            cntrl_rsp,
    output logic            cntrl_rsp_full_r,
    output ch_t             owner_r,
`ifdef OB_CMD_MUX_STATS_EN
    output logic [31:0]     stat_cmd_cnt_r [CH_N],
    output logic [31:0]     stat_rsp_cnt_r [CH_N],
`endif
    output logic [CH_N-1:0] err_ovf_r
);
    localparam int AW = CH_N > 1 ? $clog2(CH_N) : 1;
    localparam int IW = $clog2(IQ_N);
    localparam int EW = $clog2(EQ_N);
    localparam logic [IW:0] IQ_FULL = (IW + 1)'(IQ_N);
    localparam logic [IW:0] IQ_HI   = (IW + 1)'(IQ_N - 1);
    localparam logic [EW:0] EQ_FULL = (EW + 1)'(EQ_N);

    logic [CH_N-1:0] w_req;
    logic [CH_N-1:0] w_gnt;
    logic [AW-1:0]   w_idx;
    logic            w_pop;
    cmd_t            w_iq_head [CH_N];
    logic [CH_N-1:0] w_iq_hi;
    logic [CH_N-1:0] w_ovf_i;
    logic [CH_N-1:0] w_eq_push;
    logic [CH_N-1:0] w_eq_acc;
    logic [CH_N-1:0] w_eq_fn;
    logic [CH_N-1:0] w_ovf_e;
    logic [CH_N-1:0] r_eq_full;
    logic [AW-1:0]   r_owner;

    ob_cmd_mux_rr_arb #(.N(CH_N)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_req),
        .i_accept (w_pop),
        .o_gnt    (w_gnt),
        .o_idx    (w_idx)
    );

    assign cntrl_cmd_vld    = |w_req;
    assign cntrl_cmd        = w_iq_head[w_idx];
    assign w_pop            = cntrl_cmd_pop & cntrl_cmd_vld;
    assign owner_r          = ch_t'(r_owner);
    assign cntrl_rsp_full_r = r_eq_full[r_owner];

    for (genvar g = 0; g < CH_N; g++) begin : g_ch
        cmd_t          r_iq_mem [IQ_N];
        logic [IW-1:0] r_iq_wp;
        logic [IW-1:0] r_iq_rp;
        logic [IW:0]   r_iq_cnt;
        logic [IW:0]   w_iq_nxt;
        logic          w_iq_pop;
        logic          w_iq_acc;
        rsp_t          r_eq_mem [EQ_N];
        logic [EW-1:0] r_eq_wp;
        logic [EW-1:0] r_eq_rp;
        logic [EW:0]   r_eq_cnt;
        logic [EW:0]   w_eq_nxt;
        logic          w_eq_pop;

        // A full queue still takes a push when it is popped in the same cycle.
        assign w_iq_pop     = w_pop & w_gnt[g];
        assign w_iq_acc     = cmd_vld_r[g] & (r_iq_cnt != IQ_FULL || w_iq_pop);
        assign w_iq_nxt     = r_iq_cnt + (IW + 1)'(w_iq_acc) - (IW + 1)'(w_iq_pop);
        assign w_iq_hi[g]   = w_iq_nxt >= IQ_HI;
        assign w_ovf_i[g]   = cmd_vld_r[g] & ~w_iq_acc;
        assign w_req[g]     = r_iq_cnt != '0;
        assign w_iq_head[g] = r_iq_mem[r_iq_rp];

        always_ff @(posedge clk)
            if (w_iq_acc) r_iq_mem[r_iq_wp] <= cmd_r[g];

        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                r_iq_wp  <= '0;
                r_iq_rp  <= '0;
                r_iq_cnt <= '0;
            end else begin
                r_iq_wp  <= r_iq_wp + IW'(w_iq_acc);
                r_iq_rp  <= r_iq_rp + IW'(w_iq_pop);
                r_iq_cnt <= w_iq_nxt;
            end

        assign w_eq_push[g] = cntrl_rsp_vld & (r_owner == AW'(g));
        assign w_eq_pop     = rsp_vld[g] & rsp_accept[g];
        assign w_eq_acc[g]  = w_eq_push[g] & (r_eq_cnt != EQ_FULL || w_eq_pop);
        assign w_eq_nxt     = r_eq_cnt + (EW + 1)'(w_eq_acc[g]) - (EW + 1)'(w_eq_pop);
        assign w_eq_fn[g]   = w_eq_nxt == EQ_FULL;
        assign w_ovf_e[g]   = w_eq_push[g] & ~w_eq_acc[g];
        assign rsp_vld[g]   = r_eq_cnt != '0;
        assign rsp[g]       = r_eq_mem[r_eq_rp];

        always_ff @(posedge clk)
            if (w_eq_acc[g]) r_eq_mem[r_eq_wp] <= cntrl_rsp;

        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                r_eq_wp  <= '0;
                r_eq_rp  <= '0;
                r_eq_cnt <= '0;
            end else begin
                r_eq_wp  <= r_eq_wp + EW'(w_eq_acc[g]);
                r_eq_rp  <= r_eq_rp + EW'(w_eq_pop);
                r_eq_cnt <= w_eq_nxt;
            end
    end

    // Responses route by the owner held before this cycle's pop takes effect.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cmd_full_r <= '0;
            r_eq_full  <= '0;
            err_ovf_r  <= '0;
            r_owner    <= '0;
        end else begin
            cmd_full_r <= w_iq_hi;
            r_eq_full  <= w_eq_fn;
            err_ovf_r  <= err_ovf_r | w_ovf_i | w_ovf_e;
            if (w_pop) r_owner <= w_idx;
        end

`ifdef OB_CMD_MUX_STATS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            for (int i = 0; i < CH_N; i++) begin
                stat_cmd_cnt_r[i] <= '0;
                stat_rsp_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH_N; i++) begin
                stat_cmd_cnt_r[i] <= stat_cmd_cnt_r[i] + 32'(w_pop & w_gnt[i]);
                stat_rsp_cnt_r[i] <= stat_rsp_cnt_r[i] + 32'(w_eq_acc[i]);
            end
        end
`endif
endmodule

// File: tb/tb_ob_cmd_mux.sv
// tb_ob_cmd_mux: directed scoreboard bench for ob_cmd_mux (CH_N=4, IQ_N=4, EQ_N=4).
module tb_ob_cmd_mux;
    import ob_cmd_mux_pkg::*;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] cmd_vld_r = '0;
    cmd_t          cmd_r [CH];
    logic [CH-1:0] cmd_full_r;
    logic [CH-1:0] rsp_accept = '0;
    logic [CH-1:0] rsp_vld;
    rsp_t          rsp [CH];
    logic          cntrl_cmd_vld;
    cmd_t          cntrl_cmd;
    logic          cntrl_cmd_pop = 1'b0;
    logic          cntrl_rsp_vld = 1'b0;
    rsp_t          cntrl_rsp = '0;
    logic          cntrl_rsp_full_r;
    ch_t           owner_r;
    logic [CH-1:0] err_ovf_r;
`ifdef OB_CMD_MUX_STATS_EN
    logic [31:0]   stat_cmd_cnt_r [CH];
    logic [31:0]   stat_rsp_cnt_r [CH];
`endif

    int   checks = 0;
    int   errors = 0;
    cmd_t exp_cmd [$];
    rsp_t exp_rsp [$];

    always #5 clk = ~clk;

    ob_cmd_mux #(.CH_N(CH), .IQ_N(4), .EQ_N(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_vld_r        (cmd_vld_r),
        .cmd_r            (cmd_r),
        .cmd_full_r       (cmd_full_r),
        .rsp_accept       (rsp_accept),
        .rsp_vld          (rsp_vld),
        .rsp              (rsp),
        .cntrl_cmd_vld    (cntrl_cmd_vld),
        .cntrl_cmd        (cntrl_cmd),
        .cntrl_cmd_pop    (cntrl_cmd_pop),
        .cntrl_rsp_vld    (cntrl_rsp_vld),
        .cntrl_rsp        (cntrl_rsp),
        .cntrl_rsp_full_r (cntrl_rsp_full_r),
        .owner_r          (owner_r),
`ifdef OB_CMD_MUX_STATS_EN
        .stat_cmd_cnt_r   (stat_cmd_cnt_r),
        .stat_rsp_cnt_r   (stat_rsp_cnt_r),
`endif
        .err_ovf_r        (err_ovf_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and retire single-cycle pulses.
    task automatic step();
        @(negedge clk);
        cmd_vld_r     = '0;
        cntrl_rsp_vld = 1'b0;
        cntrl_cmd_pop = 1'b0;
    endtask

    task automatic push_cmd(input int ch, input cmd_t c);
        cmd_vld_r[ch] = 1'b1;
        cmd_r[ch]     = c;
    endtask

    task automatic push_rsp(input rsp_t r);
        cntrl_rsp_vld = 1'b1;
        cntrl_rsp     = r;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        cmd_t c;
        rsp_t r;
        for (int i = 0; i < CH; i++) cmd_r[i] = '0;
        step();
        chk("rst_cntrl_vld", 64'(cntrl_cmd_vld), 0);
        chk("rst_rsp_vld", 64'(rsp_vld), 0);
        chk("rst_cmd_full", 64'(cmd_full_r), 0);
        chk("rst_rsp_full", 64'(cntrl_rsp_full_r), 0);
        chk("rst_owner", 64'(owner_r), 0);
        chk("rst_err", 64'(err_ovf_r), 0);
        do_reset();

        // single command on ch2, then pointer sits at 3
        c = cmd_t'(32'h4000_0A02);
        push_cmd(2, c);
        exp_cmd.push_back(c);
        chk("t1_no_same_cycle", 64'(cntrl_cmd_vld), 0);
        step();
        chk("t1_vld", 64'(cntrl_cmd_vld), 1);
        chk("t1_cmd", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        cntrl_cmd_pop = 1'b1;
        step();
        chk("t1_owner", 64'(owner_r), 2);
        chk("t1_idle", 64'(cntrl_cmd_vld), 0);
        c = cmd_t'(32'h0000_0030);
        push_cmd(0, c);
        c = cmd_t'(32'hC000_0033);
        push_cmd(3, c);
        exp_cmd.push_back(cmd_t'(32'hC000_0033));
        exp_cmd.push_back(cmd_t'(32'h0000_0030));
        step();
        chk("t1_ptr3_first", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        cntrl_cmd_pop = 1'b1;
        step();
        chk("t1_ptr3_second", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        chk("t1_owner3", 64'(owner_r), 3);
        cntrl_cmd_pop = 1'b1;
        step();
        chk("t1_owner0", 64'(owner_r), 0);
        chk("t1_drained", 64'(cntrl_cmd_vld), 0);

        // round robin over channels 0, 1, 3
        do_reset();
        for (int i = 0; i < CH; i++) begin
            if (i != 2) begin
                c = cmd_t'(32'h1000_0100 + 32'(i));
                push_cmd(i, c);
                exp_cmd.push_back(c);
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            chk("t2_vld", 64'(cntrl_cmd_vld), 1);
            chk("t2_order", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
            cntrl_cmd_pop = 1'b1;
            step();
        end
        chk("t2_idle", 64'(cntrl_cmd_vld), 0);
        chk("t2_owner", 64'(owner_r), 3);
        c = cmd_t'(32'h2000_0200);
        push_cmd(0, c);
        exp_cmd.push_back(c);
        c = cmd_t'(32'h2000_0201);
        push_cmd(1, c);
        exp_cmd.push_back(c);
        step();
        chk("t2_wrap_ch0", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        cntrl_cmd_pop = 1'b1;
        step();
        chk("t2_then_ch1", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        chk("t2_owner0", 64'(owner_r), 0);
        cntrl_cmd_pop = 1'b1;
        step();

        // ingress overflow on ch1
        do_reset();
        for (int k = 0; k < 5; k++) begin
            c = cmd_t'(32'h8000_1000 + 32'(k + 1));
            push_cmd(1, c);
            if (k < 4) exp_cmd.push_back(c);
            step();
            chk("t3_full", 64'(cmd_full_r), (k >= 2) ? 64'h2 : 64'h0);
            chk("t3_err", 64'(err_ovf_r), (k == 4) ? 64'h2 : 64'h0);
        end
        for (int j = 0; j < 4; j++) begin
            chk("t3_vld", 64'(cntrl_cmd_vld), 1);
            chk("t3_order", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
            cntrl_cmd_pop = 1'b1;
            step();
            chk("t3_full_drain", 64'(cmd_full_r[1]), (j == 0) ? 64'h1 : 64'h0);
        end
        chk("t3_empty", 64'(cntrl_cmd_vld), 0);

        // responses stay with the previous owner across a same-cycle pop
        do_reset();
        c = cmd_t'(32'h4000_00A0);
        push_cmd(0, c);
        exp_cmd.push_back(c);
        c = cmd_t'(32'h4000_00B1);
        push_cmd(1, c);
        exp_cmd.push_back(c);
        step();
        chk("t4_cmd0", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        cntrl_cmd_pop = 1'b1;
        step();
        chk("t4_owner0", 64'(owner_r), 0);
        chk("t4_cmd1", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        for (int k = 0; k < 3; k++) begin
            r = rsp_t'(32'h4000_0F00 + 32'(k));
            push_rsp(r);
            exp_rsp.push_back(r);
            if (k == 2) cntrl_cmd_pop = 1'b1;
            if (k < 2) step();
        end
        step();
        chk("t4_owner1", 64'(owner_r), 1);
        chk("t4_ch1_no_rsp", 64'(rsp_vld[1]), 0);
        for (int k = 0; k < 3; k++) begin
            chk("t4_rsp_vld", 64'(rsp_vld[0]), 1);
            chk("t4_rsp", 64'(rsp[0]), 64'(exp_rsp.pop_front()));
            rsp_accept[0] = 1'b1;
            step();
        end
        rsp_accept[0] = 1'b0;
        chk("t4_rsp_done", 64'(rsp_vld), 0);

        // egress full and overflow on ch2
        do_reset();
        c = cmd_t'(32'hC000_0C02);
        push_cmd(2, c);
        exp_cmd.push_back(c);
        step();
        chk("t5_cmd", 64'(cntrl_cmd), 64'(exp_cmd.pop_front()));
        cntrl_cmd_pop = 1'b1;
        step();
        chk("t5_owner", 64'(owner_r), 2);
        for (int k = 0; k < 4; k++) begin
            r = rsp_t'(32'h8000_0500 + 32'(k));
            push_rsp(r);
            exp_rsp.push_back(r);
            step();
            chk("t5_rsp_full", 64'(cntrl_rsp_full_r), (k == 3) ? 64'h1 : 64'h0);
        end
        push_rsp(rsp_t'(32'hFFFF_FFFF));
        step();
        chk("t5_err", 64'(err_ovf_r), 64'h4);
        chk("t5_ch3_clean", 64'(rsp_vld), 64'h4);
        rsp_accept[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t5_drain", 64'(rsp[2]), 64'(exp_rsp.pop_front()));
            step();
        end
        rsp_accept[2] = 1'b0;
        chk("t5_no_extra", 64'(rsp_vld[2]), 0);
        chk("t5_unfull", 64'(cntrl_rsp_full_r), 0);

        // asynchronous reset with traffic in flight
        for (int k = 0; k < 3; k++) begin
            push_cmd(0, cmd_t'(32'h0000_7000 + 32'(k)));
            push_cmd(1, cmd_t'(32'h0000_7100 + 32'(k)));
            if (k < 2) push_rsp(rsp_t'(32'h0000_7200 + 32'(k)));
            step();
        end
        chk("t6_pre_full", 64'(cmd_full_r), 64'h3);
        chk("t6_pre_rsp", 64'(rsp_vld), 64'h4);
        rst = 1'b0;
        #1;
        chk("t6_rsp_vld", 64'(rsp_vld), 0);
        chk("t6_cmd_full", 64'(cmd_full_r), 0);
        chk("t6_cntrl_vld", 64'(cntrl_cmd_vld), 0);
        chk("t6_err", 64'(err_ovf_r), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_stale_rsp", 64'(rsp_vld), 0);
            chk("t6_stale_cmd", 64'(cntrl_cmd_vld), 0);
        end
        chk("sb_cmd_empty", 64'(exp_cmd.size()), 0);
        chk("sb_rsp_empty", 64'(exp_rsp.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ob_cmd_mux.md
Name: ob_cmd_mux

Overview:
Multi-channel front end for the order-book controller. It takes CH_N independent command ports and buffers each in its own ingress queue. A round-robin arbiter presents one command at a time to ob_cntrl. Responses go back to the channel whose command is in flight, through per-channel egress queues. It generalises the single-port ingress/egress shell to N channels, with overflow detection and ownership tracking.

Parameters:
CH_N, 4, number of command/response channels (1..16)
IQ_N, 4, per-channel ingress queue depth (power of 2, >=2)
EQ_N, 4, per-channel egress queue depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cmd_vld_r  in  CH_N  per-channel registered command valid
cmd_r  in  CH_N x ob_pkg::cmd_t  per-channel command
cmd_full_r  out  CH_N  per-channel ingress backpressure (registered)
rsp_accept  in  CH_N  per-channel response accept
rsp_vld  out  CH_N  per-channel response valid
rsp  out  CH_N x ob_pkg::rsp_t  per-channel response
cntrl_cmd_vld  out  1  arbitrated command available
cntrl_cmd  out  ob_pkg::cmd_t  arbitrated command
cntrl_cmd_pop  in  1  controller consumes cntrl_cmd
cntrl_rsp_vld  in  1  controller response valid
cntrl_rsp  in  ob_pkg::rsp_t  controller response
cntrl_rsp_full_r  out  1  owner egress queue full (registered flag)
owner_r  out  ob_pkg::ch_t  channel of last popped command
err_ovf_r  out  CH_N  sticky overflow, bit per channel (ingress or egress drop)

Behaviour:
- Reset (rst=0, async): all queues empty; cmd_full_r=0, rsp_vld=0, cntrl_cmd_vld=0, cntrl_rsp_full_r=0, owner_r=0, err_ovf_r=0, RR pointer=0.
- Ingress push: cmd_vld_r[i] pushes cmd_r[i] unconditionally; commit in the same cycle.
- cmd_full_r[i] is registered. It asserts when post-update occupancy >= IQ_N-1, leaving one slot of slack for the upstream register stage.
- Push into a full queue (occupancy==IQ_N, no pop that cycle): data dropped, err_ovf_r[i] sets. Push and pop together on a full queue: accepted, no error.
- Arbitration: requests are the channels with a registered non-empty queue.
- Grant: first requester at or after RR pointer, wrapping CH_N-1 -> 0.
- cntrl_cmd_vld = any request. cntrl_cmd = head of the granted queue (combinational from registered state).
- Pop: cntrl_cmd_pop with cntrl_cmd_vld pops the granted queue. Next cycle owner_r = granted channel and RR pointer = grant+1 (mod CH_N). The pointer is unchanged when there is no pop.
- cntrl_cmd_pop without cntrl_cmd_vld is ignored.
- Ingress latency: command at cmd_vld_r in cycle t reaches cntrl_cmd_vld in cycle t+1 at the earliest.
- Response routing: cntrl_rsp_vld pushes cntrl_rsp into egress[owner_r], using owner_r before any same-cycle update.
- A response in the same cycle as a pop of a new command goes to the previous owner.
- Multiple responses per command (fills plus acknowledgement) all go to the owner.
- cntrl_rsp_full_r = registered full flag of egress[owner_r]. Controller holds responses while it is high.
- Egress push to a full queue: dropped, err_ovf_r[owner_r] sets.
- Egress output: rsp_vld[i] = egress i registered non-empty; rsp[i] = head. Pop on rsp_vld[i] & rsp_accept[i]; channels are independent.
- Reset mid-operation: all in-flight contents discarded. No response is emitted after rst deasserts until new commands are popped.
- CH_N=1: arbiter degenerates to a pass-through and owner_r is constant 0.

Optional Feature:
OB_CMD_MUX_STATS_EN:
- Defined: adds output stat_cmd_cnt_r (CH_N x 32) counting pops per channel and stat_rsp_cnt_r (CH_N x 32) counting egress pushes per channel. Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- ob_pkg gains typedef ch_t (logic [$clog2(CH_MAX)-1:0], CH_MAX=16).
- cfg_pkg gains OB_CH_N, OB_IQ_N and OB_EQ_N defaults.
- Queues use the existing libv_queue.
- One sub-module, ob_rr_arb: parametrised round-robin arbiter, requests in, one-hot grant plus encoded index out, pointer advance on an accept input.

Test Plan:
- Reset then idle: all outputs 0; cmd on ch2 only -> cntrl_cmd_vld at t+1 with that cmd; pop -> owner_r=2, pointer=3.
- Channels 0, 1 and 3 each push one cmd, pop every cycle -> grant order 0, 1, 3; then a cmd on ch0 -> granted next.
- IQ_N=4, ch1 pushes 5 cmds back-to-back, no pops:
  - cmd_full_r[1] high after 3rd push.
  - 5th push dropped, err_ovf_r[1]=1.
  - Pop yields cmds 1-4 in order.
- Pop ch0 cmd, controller returns 3 rsps; same cycle as 3rd rsp, pop ch1 cmd -> all 3 rsps on ch0, owner_r=1 the next cycle.
- ch2 rsp_accept held 0, controller pushes EQ_N rsps -> cntrl_rsp_full_r=1; extra push dropped, err_ovf_r[2]=1; ch3 unaffected.
- Assert rst mid-traffic with queues half full -> all rsp_vld=0 and cmd_full_r=0 immediately; no stale output afterward.
